// File: rtl/rng_range.sv
// rng_range: maximal-length Fibonacci LFSR with reseeding and a valid/ready bounded-range sampler.
// Define RNG_REJECT_EN for bounded rejection sampling; otherwise a single biased fold is used.
module rng_range #(
    parameter int          WIDTH     = 16,
    parameter logic [31:0] SEED      = 32'h0000_0F2C,
    parameter int          OUT_W     = 8,
    parameter int          MAX_TRIES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             seed_valid_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [OUT_W-1:0] range_i,
    output logic             rnd_valid_o,
    input  logic             rnd_ready_i,
    output logic [OUT_W-1:0] rnd_num_o,
    output logic [WIDTH-1:0] raw_o
);

    // One bit per 1-indexed tap, bit (tap-1).
    localparam logic [31:0] TAPS =
        (WIDTH == 8)  ? 32'h0000_00B8 :
        (WIDTH == 16) ? 32'h0000_D008 :
        (WIDTH == 24) ? 32'h00E1_0000 :
                        32'h8020_0003;
    localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];

    if (WIDTH != 8 && WIDTH != 16 && WIDTH != 24 && WIDTH != 32) begin : g_bad_width
        $error("rng_range: WIDTH must be 8, 16, 24 or 32");
    end
    if (SEED_W == '0) begin : g_bad_seed
        $error("rng_range: SEED truncated to WIDTH must be non-zero");
    end
    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
        $error("rng_range: OUT_W must be in 1..WIDTH");
    end

    typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] seed_eff;
    logic             lfsr_zero;
    logic             load;
    logic             step;
    logic [OUT_W:0]   lim;
    logic [OUT_W-1:0] mask;
    logic [OUT_W-1:0] cand;
    logic             accept;
    logic [OUT_W-1:0] folded;

`ifdef RNG_REJECT_EN
    localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    if (MAX_TRIES < 1) begin : g_bad_tries
        $error("rng_range: MAX_TRIES must be at least 1");
    end

    logic [TRY_W-1:0] tries;
`endif

    // Smallest 2^k-1 covering range-1; range 0 wraps to all ones, i.e. 2^OUT_W.
    function automatic logic [OUT_W-1:0] mask_of(input logic [OUT_W-1:0] r);
        logic [OUT_W-1:0] m;
        m = r - 1'b1;
        for (int i = 1; i < OUT_W; i++) begin
            m = m | (m >> i);
        end
        return m;
    endfunction

    assign lfsr_zero = (lfsr == '0);
    assign load      = lfsr_zero | seed_valid_i;
    assign step      = !load && (en_i || state == DRAW);
    assign lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAP_MASK)};
    assign seed_eff  = (!lfsr_zero && seed_i != '0) ? seed_i : SEED_W;

    // A rejected candidate is below 2*range, so one subtraction lands it inside [0, range).
    assign cand   = lfsr[OUT_W-1:0] & mask;
    assign accept = ({1'b0, cand} < lim);
    assign folded = accept ? cand : cand - lim[OUT_W-1:0];

    assign raw_o = lfsr;

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr        <= SEED_W;
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rnd_valid_o <= 1'b0;
            rnd_num_o   <= '0;
            lim         <= '0;
            mask        <= '0;
`ifdef RNG_REJECT_EN
            tries       <= '0;
`endif
        end else begin
            if (load) begin
                lfsr <= seed_eff;
            end else if (step) begin
                lfsr <= lfsr_next;
            end

            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        lim         <= {(range_i == '0), range_i};
                        mask        <= mask_of(range_i);
`ifdef RNG_REJECT_EN
                        tries       <= '0;
`endif
                        req_ready_o <= 1'b0;
                        state       <= DRAW;
                    end
                end
                DRAW: begin
                    // A load cycle stalls the draw; it resumes on the freshly loaded state.
                    if (!load) begin
`ifdef RNG_REJECT_EN
                        tries <= tries + 1'b1;
                        if (accept || tries == LAST_TRY) begin
                            rnd_num_o   <= folded;
                            rnd_valid_o <= 1'b1;
                            state       <= HOLD;
                        end
`else
                        rnd_num_o   <= folded;
                        rnd_valid_o <= 1'b1;
                        state       <= HOLD;
`endif
                    end
                end
                HOLD: begin
                    if (rnd_ready_i) begin
                        rnd_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rnd_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_range.sv
// Directed bench for rng_range: a MAX_TRIES=4 instance plus a MAX_TRIES=1 instance for fallback/stall cases.
// Expectations follow RNG_REJECT_EN so the same bench covers both builds.
module tb_rng_range;

`ifdef RNG_REJECT_EN
    localparam bit REJ = 1'b1;
`else
    localparam bit REJ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        seed_valid;
    logic [15:0] seed;
    logic        req_valid;
    logic        req_valid1;
    logic [7:0]  range_in;
    logic        rnd_ready;

    logic        req_ready,  req_ready1;
    logic        rnd_valid,  rnd_valid1;
    logic [7:0]  rnd_num,    rnd_num1;
    logic [15:0] raw,        raw1;

    int checks = 0;
    int passed = 0;
    int lat;

    always #5 clk = ~clk;

    rng_range #(.WIDTH(16), .SEED(32'h0F2C), .OUT_W(8), .MAX_TRIES(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .seed_valid_i(seed_valid), .seed_i(seed),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .range_i(range_in),
        .rnd_valid_o(rnd_valid), .rnd_ready_i(rnd_ready), .rnd_num_o(rnd_num), .raw_o(raw)
    );

    rng_range #(.WIDTH(16), .SEED(32'h0F2C), .OUT_W(8), .MAX_TRIES(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .seed_valid_i(seed_valid), .seed_i(seed),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1), .range_i(range_in),
        .rnd_valid_o(rnd_valid1), .rnd_ready_i(rnd_ready), .rnd_num_o(rnd_num1), .raw_o(raw1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Handshake on the main instance, then count cycles until rnd_valid (bounded).
    task automatic request(input logic [7:0] r, output int l);
        check("req_ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        range_in  = r;
        tick();
        req_valid = 1'b0;
        l = 1;
        while (!rnd_valid && l < 8) begin
            tick();
            l++;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        seed_valid = 1'b0;
        seed       = '0;
        req_valid  = 1'b0;
        req_valid1 = 1'b0;
        range_in   = '0;
        rnd_ready  = 1'b1;

        // Reset values and free run
        do_reset();
        check("reset_raw",       raw,       16'h0F2C);
        check("reset_req_ready", req_ready, 1);
        check("reset_rnd_valid", rnd_valid, 0);
        check("reset_rnd_num",   rnd_num,   0);
        en = 1'b1;
        tick();
        check("run_raw_1", raw, 16'h1E59);
        tick();
        check("run_raw_2", raw, 16'h3CB2);
        check("run_req_ready", req_ready, 1);
        check("run_rnd_valid", rnd_valid, 0);
        en = 1'b0;

        // Rejection then accept, range 10
        do_reset();
        request(8'd10, lat);
        check("rej_latency", lat, REJ ? 3 : 2);
        check("rej_valid",   rnd_valid, 1);
        check("rej_result",  rnd_num, REJ ? 8'd9 : 8'd2);
        check("rej_raw",     raw, REJ ? 16'h3CB2 : 16'h1E59);
        check("rej_hold_ready", req_ready, 0);
        tick();
        check("rej_idle_valid", rnd_valid, 0);
        check("rej_idle_ready", req_ready, 1);

        // Backpressure: result held for 5 cycles
        do_reset();
        rnd_ready = 1'b0;
        request(8'd10, lat);
        check("bp_latency", lat, REJ ? 3 : 2);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_num",   rnd_num,   REJ ? 8'd9 : 8'd2);
            check("bp_hold_valid", rnd_valid, 1);
            check("bp_hold_ready", req_ready, 0);
            tick();
        end
        rnd_ready = 1'b1;
        check("bp_last_num", rnd_num, REJ ? 8'd9 : 8'd2);
        tick();
        check("bp_idle_valid", rnd_valid, 0);
        check("bp_idle_ready", req_ready, 1);

        // Zero seed, range 1 and full range
        seed_valid = 1'b1;
        seed       = 16'h0000;
        tick();
        seed_valid = 1'b0;
        check("zero_seed_raw", raw, 16'h0F2C);
        request(8'd1, lat);
        check("range1_latency", lat, 2);
        check("range1_result",  rnd_num, 8'd0);
        check("range1_raw",     raw, 16'h1E59);
        tick();
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        check("reseed_raw", raw, 16'h0F2C);
        request(8'd0, lat);
        check("range0_latency", lat, 2);
        check("range0_result",  rnd_num, 8'h2C);
        tick();
        en         = 1'b1;
        seed_valid = 1'b1;
        seed       = 16'h1234;
        tick();
        seed_valid = 1'b0;
        check("seed_beats_step", raw, 16'h1234);
        tick();
        check("step_after_seed", raw, 16'h2469);
        en = 1'b0;

        // MAX_TRIES=1 fallback: cand 12, range 10 -> 2
        do_reset();
        req_valid1 = 1'b1;
        range_in   = 8'd10;
        tick();
        req_valid1 = 1'b0;
        lat = 1;
        while (!rnd_valid1 && lat < 8) begin
            tick();
            lat++;
        end
        check("fallback_latency", lat, 2);
        check("fallback_result",  rnd_num1, 8'd2);
        check("fallback_raw",     raw1, 16'h1E59);
        tick();
        check("fallback_idle", req_ready1, 1);

        // Seed during DRAW stalls without counting; reset during HOLD
        do_reset();
        rnd_ready  = 1'b0;
        req_valid  = 1'b1;
        req_valid1 = 1'b1;
        range_in   = 8'd10;
        tick();
        req_valid  = 1'b0;
        req_valid1 = 1'b0;
        seed_valid = 1'b1;
        seed       = 16'h1E59;
        tick();
        seed_valid = 1'b0;
        check("stall_raw",    raw, 16'h1E59);
        check("stall_valid",  rnd_valid, 0);
        check("stall_valid1", rnd_valid1, 0);
        tick();
        check("resume_valid",   rnd_valid, 1);
        check("resume_result",  rnd_num, 8'd9);
        check("resume_raw",     raw, 16'h3CB2);
        check("resume_valid1",  rnd_valid1, 1);
        check("resume_result1", rnd_num1, 8'd9);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("hold_rst_valid", rnd_valid, 0);
        check("hold_rst_raw",   raw, 16'h0F2C);
        check("hold_rst_ready", req_ready, 1);
        check("hold_rst_num",   rnd_num, 0);
        rnd_ready = 1'b1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
